// File: rtl/lsu_if.sv
// Core-side request/response and memory-bus signals of the load/store unit.
// The slave modport is the LSU's view; the master modport is the core/memory side.
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [2:0]  req_mode;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    logic        bus_req;
    logic        bus_we;
    logic [29:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_err;

    modport slave (
        input  req_valid, req_wen, req_mode, req_addr, req_wdata,
        input  bus_ack, bus_rdata, bus_err,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata
    );

    modport master (
        output req_valid, req_wen, req_mode, req_addr, req_wdata,
        output bus_ack, bus_rdata, bus_err,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata
    );
endinterface

// File: rtl/lsu.sv
// Load/store unit: one RV32I access at a time onto a word-addressed, byte-enabled
// req/ack bus, with alignment/legality checking, bus timeout and load extension.
module lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    lsu_if.slave io
);
    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [2:0] MODE_B  = 3'b000;
    localparam logic [2:0] MODE_H  = 3'b001;
    localparam logic [2:0] MODE_W  = 3'b010;
    localparam logic [2:0] MODE_BU = 3'b100;
    localparam logic [2:0] MODE_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               wen_q, wen_d;
    logic [2:0]         mode_q, mode_d;
    logic [1:0]         off_q, off_d;
    logic               bus_req_q, bus_req_d;
    logic               bus_we_q, bus_we_d;
    logic [29:0]        bus_addr_q, bus_addr_d;
    logic [3:0]         bus_be_q, bus_be_d;
    logic [31:0]        bus_wdata_q, bus_wdata_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;
    logic               busy_q, busy_d;
    logic               ready_q, ready_d;

    logic               bad_c;
    logic [3:0]         be_c;
    logic [31:0]        wdata_c;
    logic [15:0]        sh_c;
    logic [31:0]        load_c;

    // Legality and alignment of the request currently presented by the core
    always_comb begin
        if (io.req_wen)
            bad_c = !(io.req_mode inside {MODE_B, MODE_H, MODE_W});
        else
            bad_c = io.req_mode inside {3'b011, 3'b110, 3'b111};
        if ((io.req_mode == MODE_H || io.req_mode == MODE_HU) && io.req_addr[0])
            bad_c = 1'b1;
        if (io.req_mode == MODE_W && io.req_addr[1:0] != 2'b00)
            bad_c = 1'b1;
    end

    // Byte enables and lane-replicated store data
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = io.req_wdata;
        case (io.req_mode[1:0])
            2'b00: begin
                be_c    = 4'(4'b0001 << io.req_addr[1:0]);
                wdata_c = {4{io.req_wdata[7:0]}};
            end
            2'b01: begin
                be_c    = 4'(4'b0011 << {io.req_addr[1], 1'b0});
                wdata_c = {2{io.req_wdata[15:0]}};
            end
            default: ;
        endcase
        if (!io.req_wen)
            wdata_c = '0;
    end

    // Align the addressed byte/half to bit 0 and extend
    always_comb begin
        sh_c = 16'(io.bus_rdata >> {off_q, 3'b000});
        case (mode_q)
            MODE_B:  load_c = {{24{sh_c[7]}}, sh_c[7:0]};
            MODE_BU: load_c = {24'd0, sh_c[7:0]};
            MODE_H:  load_c = {{16{sh_c[15]}}, sh_c};
            MODE_HU: load_c = {16'd0, sh_c};
            default: load_c = io.bus_rdata;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        wen_d       = wen_q;
        mode_d      = mode_q;
        off_d       = off_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state)
            IDLE: begin
                if (io.req_valid) begin
                    wen_d  = io.req_wen;
                    mode_d = io.req_mode;
                    off_d  = io.req_addr[1:0];
                    if (bad_c) begin
                        state_d     = RESP;
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d     = BUS;
                        cnt_d       = '0;
                        bus_req_d   = 1'b1;
                        bus_we_d    = io.req_wen;
                        bus_addr_d  = io.req_addr[31:2];
                        bus_be_d    = be_c;
                        bus_wdata_d = wdata_c;
                    end
                end
            end
            BUS: begin
                if (io.bus_ack) begin
                    state_d     = RESP;
                    bus_req_d   = 1'b0;
                    bus_we_d    = 1'b0;
                    rsp_err_d   = io.bus_err;
                    rsp_rdata_d = (!wen_q && !io.bus_err) ? load_c : '0;
                end else if (TIMEOUT != 0 && cnt == CNT_W'(TIMEOUT - 1)) begin
                    // Abort; any ack arriving later is ignored outside BUS
                    state_d     = RESP;
                    bus_req_d   = 1'b0;
                    bus_we_d    = 1'b0;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else if (TIMEOUT != 0) begin
                    cnt_d = CNT_W'(cnt + 1'b1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        rsp_valid_d = (state_d == RESP);
        busy_d      = (state_d != IDLE);
        ready_d     = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            wen_q       <= 1'b0;
            mode_q      <= 3'b000;
            off_q       <= 2'b00;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            wen_q       <= wen_d;
            mode_q      <= mode_d;
            off_q       <= off_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
        end
    end

    assign io.req_ready = ready_q;
    assign io.busy      = busy_q;
    assign io.rsp_valid = rsp_valid_q;
    assign io.rsp_rdata = rsp_rdata_q;
    assign io.rsp_err   = rsp_err_q;
    assign io.bus_req   = bus_req_q;
    assign io.bus_we    = bus_we_q;
    assign io.bus_addr  = bus_addr_q;
    assign io.bus_be    = bus_be_q;
    assign io.bus_wdata = bus_wdata_q;
endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the core control/datapath and the data memory bus. It accepts one access per request from the core using `mem_en`/`mem_wen`/`mem_mode` semantics, where mode is the RV32I funct3. It drives a word-addressed, byte-enabled memory bus with a req/ack handshake and returns aligned, sign- or zero-extended load data to the register-writeback mux. It detects misaligned and illegal accesses and bus timeouts, and reports them as errors without corrupting memory.

## Interface
- `TIMEOUT`, default 255: bus cycles to wait for `bus_ack` before aborting; 0 disables the timeout.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset. One clock; reset is asynchronous and active-low.
- `req_valid`  in  1  core access request (driven from `mem_en`).
- `req_ready`  out  1  LSU can accept a request; high only in IDLE.
- `req_wen`  in  1  1 = store, 0 = load.
- `req_mode`  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data; the low byte/half is used for B/H.
- `rsp_valid`  out  1  one-cycle pulse; the access is complete.
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `rsp_err`  out  1  valid with `rsp_valid`: misaligned, illegal, bus error or timeout.
- `busy`  out  1  high whenever state ≠ IDLE; the core stalls its PC on it.
- `bus_req`  out  1  bus request, held until ack.
- `bus_we`  out  1  bus write.
- `bus_addr`  out  30  word address, equal to `req_addr[31:2]`.
- `bus_be`  out  4  byte enables.
- `bus_wdata`  out  32  lane-replicated store data.
- `bus_ack`  in  1  bus completion; sampled only while `bus_req` = 1.
- `bus_rdata`  in  32  read word; valid with `bus_ack`.
- `bus_err`  in  1  bus error; valid with `bus_ack`.

## Operation
- States:
  - IDLE: default state.
  - BUS: bus transaction outstanding.
  - RESP: response cycle.
- Accept:
  - A request is accepted when `req_valid` & `req_ready`, which can only happen in IDLE.
  - On acceptance, latch wen, mode, `addr[1:0]` and the bus fields.
- Legality check, made at acceptance:
  - Illegal for loads: mode ∈ {011, 110, 111}.
  - Illegal for stores: mode ∉ {000, 001, 010}.
  - Misaligned: H/HU with `addr[0]`=1, or W with `addr[1:0]`≠0.
  - An illegal or misaligned access goes IDLE→RESP with err=1. No bus cycle is issued and `bus_req` stays 0.
- Legal access goes IDLE→BUS:
  - `bus_be`: B = 4'b0001<<`addr[1:0]`; H = 4'b0011<<(2·`addr[1]`); W = 4'b1111.
  - `bus_be` is driven for loads as well.
  - `bus_wdata`: B = {4{wdata[7:0]}}; H = {2{wdata[15:0]}}; W = wdata.
  - `bus_wdata` is 0 for loads.
- In BUS:
  - `bus_req`, `bus_we`, `bus_addr`, `bus_be` and `bus_wdata` are registered and stay stable until the ack cycle.
  - On `bus_ack`: go to RESP. Latch err = `bus_err`. For a load with no error, latch the extracted data.
  - If `bus_err`=1, `rsp_rdata` is 0.
- Timeout:
  - A cycle counter counts BUS cycles without ack.
  - When it reaches `TIMEOUT` (TIMEOUT>0), deassert `bus_req` and go to RESP with err=1.
  - A late ack arriving after the abort is ignored.
- Load extraction:
  - Shift = 8·`addr[1:0]`; sh = `bus_rdata` >> shift.
  - B: sign-extend sh[7:0]. BU: zero-extend sh[7:0].
  - H: sign-extend sh[15:0]. HU: zero-extend sh[15:0].
  - W: `bus_rdata` unchanged.
- RESP:
  - `rsp_valid`=1 for exactly one cycle, with `rsp_rdata`/`rsp_err` from registers.
  - Then go to IDLE.
  - `rsp_rdata` and `rsp_err` hold their values until the next RESP.
- Reset:
  - Asynchronous; effective immediately, including mid-transaction.
  - State → IDLE. Counter → 0.
  - `bus_req`, `bus_we`, `bus_be`, `bus_addr`, `bus_wdata`, `rsp_valid`, `rsp_rdata`, `rsp_err`, `busy` → 0. `req_ready` → 1.
  - No response is generated for an aborted access.

## Timing
- Acceptance at edge N: `busy`=1 and `req_ready`=0 from N+1.
- Legal access:
  - `bus_req`=1 from N+1.
  - Zero-wait ack, i.e. ack in cycle N+1: `rsp_valid` in cycle N+2, IDLE at N+3.
  - Minimum latency is 2 cycles; each bus wait state adds 1.
- Illegal or misaligned access: `rsp_valid` in cycle N+1.
- `bus_req` falls on the edge after ack is sampled.
- Timeout: `bus_req` is high for exactly `TIMEOUT` cycles, then `rsp_valid` follows on the next cycle.
- `req_valid` seen while busy is ignored, not queued. The core holds the request until `req_ready`.
- Back-to-back: a new request can be accepted in the first IDLE cycle after RESP. Throughput is at most 1 access per 3 cycles.

## Test plan
- LW at 0x100 with bus returning 0xDEADBEEF and zero-wait ack:
  - `bus_addr`=0x40, `bus_be`=1111.
  - `rsp_valid` 2 cycles after acceptance.
  - `rsp_rdata`=0xDEADBEEF, err=0.
- LB and LBU at 0x103, with `bus_rdata`=0x80FF7F01:
  - LB → 0xFFFFFF80. LBU → 0x00000080.
  - LH at 0x102 → 0xFFFF80FF. LHU at 0x102 → 0x000080FF.
- SB at 0x0000_0005 with wdata=0x123456AB: `bus_be`=0010, `bus_wdata`=0xABABABAB, `bus_we`=1. SH at 0x6 with wdata=0x0000BEEF: `bus_be`=1100, `bus_wdata`=0xBEEFBEEF.
- LW at 0x102, SH at 0x001, and a store with mode 100: each gives `rsp_valid`+`rsp_err`=1 one cycle after acceptance, with `bus_req` never asserted.
- TIMEOUT=4 with no ack: `bus_req` high for 4 cycles, then `rsp_err`=1. A subsequent request with ack after 3 wait states succeeds with err=0. An ack with `bus_err`=1 gives err=1 and `rsp_rdata`=0.
- Reset asserted while in BUS with a wait state: `bus_req`, `busy` and `rsp_valid` go to 0 immediately. After release, `req_ready`=1 and no spurious `rsp_valid` appears.
